// File: rtl/oryx_isa_pkg.sv
// Shared Oryx ISA definitions: instruction field positions, format codes,
// the HALT opcode and the field-packing helper. Also used by control_unit.
package oryx_isa_pkg;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 21;
    localparam int RS1_MSB    = 20;
    localparam int RS1_LSB    = 16;
    localparam int RS2_MSB    = 15;
    localparam int RS2_LSB    = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    localparam int OP_W     = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

    // Packs a field bundle into a 32-bit word; the reserved format packs as J.
    function automatic logic [31:0] encode_instr(
        input fmt_e                fmt,
        input logic [OP_W-1:0]     op,
        input logic [REG_W-1:0]    rd,
        input logic [REG_W-1:0]    rs1,
        input logic [REG_W-1:0]    rs2,
        input logic [IMM_W-1:0]    imm,
        input logic [TARGET_W-1:0] target
    );
        logic [31:0] word;
        word = '0;
        word[OP_MSB:OP_LSB] = op;
        case (fmt)
            FMT_R: begin
                word[RD_MSB:RD_LSB]   = rd;
                word[RS1_MSB:RS1_LSB] = rs1;
                word[RS2_MSB:RS2_LSB] = rs2;
            end
            FMT_I: begin
                word[RD_MSB:RD_LSB]   = rd;
                word[RS1_MSB:RS1_LSB] = rs1;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            default: begin
                word[TARGET_MSB:TARGET_LSB] = target;
            end
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input, instruction-word output and redirect signals of the
// instruction encoder. master = encoder side, slave = source/decode side.
interface instr_encoder_if;
    import oryx_isa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_fmt;
    logic [OP_W-1:0]     in_op;
    logic [REG_W-1:0]    in_rd;
    logic [REG_W-1:0]    in_rs1;
    logic [REG_W-1:0]    in_rs2;
    logic [IMM_W-1:0]    in_imm;
    logic [TARGET_W-1:0] in_target;

    logic                ir_valid;
    logic                ir_ready;
    logic [31:0]         ir;
    logic [31:0]         ir_addr;

    logic                flush;
    logic [31:0]         flush_addr;
    logic                halted;
    logic                err;

    modport master (
        input  in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2, in_imm, in_target,
        input  ir_ready, flush, flush_addr,
        output in_ready, ir_valid, ir, ir_addr, halted, err
    );

    modport slave (
        output in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2, in_imm, in_target,
        output ir_ready, flush, flush_addr,
        input  in_ready, ir_valid, ir, ir_addr, halted, err
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with a registered head word and registered empty flag.
// clear empties the FIFO and takes priority over push and pop.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count == (AW+1)'(DEPTH));
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    assign count_nxt  = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    // Storage array write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
                head <= din;
            end else if (count_nxt != '0) begin
                head <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and issue buffer: packs field bundles into 32-bit words,
// queues them and issues them in order with their byte addresses; input
// closes after a HALT word until flush.
// Optional build macro: INSTR_ENC_CHECK_EN (reserved format dropped, sticky err).
module instr_encoder
    import oryx_isa_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.master bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  state;
    fmt_e        fmt;
    logic [31:0] word;
    logic        accept;
    logic        rsv_drop;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign fmt  = fmt_e'(bus.in_fmt);
    assign word = encode_instr(fmt, bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2,
                               bus.in_imm, bus.in_target);

`ifdef INSTR_ENC_CHECK_EN
    assign rsv_drop = (fmt == FMT_RSV);
`else
    assign rsv_drop = 1'b0;
`endif

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign push   = accept && !rsv_drop;
    assign pop    = !fifo_empty && bus.ir_ready && !bus.flush;

    assign bus.in_ready = !fifo_full && (state == ST_RUN);
    assign bus.ir_valid = !fifo_empty;
    assign bus.halted   = (state == ST_HALT);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .din   (word),
        .head  (bus.ir),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // RUN/HALT control: a pushed HALT word closes input, only flush reopens it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (bus.flush) begin
            state <= ST_RUN;
        end else if (push && (bus.in_op == OP_HALT)) begin
            state <= ST_HALT;
        end
    end

    // Issue address: redirected by flush, otherwise steps by 4 per issued word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ir_addr <= BASE_ADDR;
        end else if (bus.flush) begin
            bus.ir_addr <= bus.flush_addr;
        end else if (pop) begin
            bus.ir_addr <= bus.ir_addr + 32'd4;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    // Sticky error on any accepted reserved-format bundle; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err <= 1'b0;
        end else if (accept && (fmt == FMT_RSV)) begin
            bus.err <= 1'b1;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
// Honours INSTR_ENC_CHECK_EN the same way as the design.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp_word;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    vec_t        vecs [6];
    logic [31:0] mq [$];
    logic [31:0] m_addr;
    bit          m_halt;
    bit          m_err;

    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference packing from plain field weights (op * 2^26, rd * 2^21, ...).
    function automatic logic [31:0] ref_word(input logic [1:0] fmt, input logic [5:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [15:0] imm,
                                             input logic [25:0] target);
        logic [63:0] w;
        w = 64'(op) * 64'h400_0000;
        if (fmt == 2'd0)
            w = w + 64'(rd) * 64'h20_0000 + 64'(rs1) * 64'h1_0000 + 64'(rs2) * 64'h800;
        else if (fmt == 2'd1)
            w = w + 64'(rd) * 64'h20_0000 + 64'(rs1) * 64'h1_0000 + 64'(imm);
        else
            w = w + 64'(target);
        return w[31:0];
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_flag(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [1:0] fmt, input logic [5:0] op,
                                  input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [15:0] imm, input logic [25:0] target);
        bus.in_valid  = v;
        bus.in_fmt    = fmt;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_target = target;
    endtask

    task automatic do_flush(input logic [31:0] addr);
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b1;
        bus.flush_addr = addr;
        tick();
        bus.flush      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_flag  ({tag, " ir_valid"}, bus.ir_valid, 1'b0);
        check_output({tag, " ir"},       bus.ir,       32'h0);
        check_output({tag, " ir_addr"},  bus.ir_addr,  BASE);
        check_flag  ({tag, " in_ready"}, bus.in_ready, 1'b1);
        check_flag  ({tag, " halted"},   bus.halted,   1'b0);
        check_flag  ({tag, " err"},      bus.err,      1'b0);
    endtask

    initial begin
        logic [31:0] fw [DEPTH];

        vecs[0] = '{2'd1, 6'h02, 5'd2,  5'd0,  5'd0,  16'h0008, 26'h0,       32'h0840_0008};
        vecs[1] = '{2'd0, 6'h01, 5'd3,  5'd4,  5'd5,  16'hFFFF, 26'h3FF_FFFF, 32'h0464_2800};
        vecs[2] = '{2'd2, 6'h02, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h0AB_CDEF, 32'h08AB_CDEF};
        vecs[3] = '{2'd1, 6'h23, 5'h1F, 5'h01, 5'h1F, 16'h8001, 26'h3FF_FFFF, 32'h8FE1_8001};
        vecs[4] = '{2'd0, 6'h3E, 5'd0,  5'h1F, 5'h1F, 16'h0000, 26'h0,       32'hF81F_F800};
        vecs[5] = '{2'd2, 6'h00, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF, 32'h03FF_FFFF};

        apply_stimulus(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        bus.ir_ready   = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_addr = 32'h0;

        // Reset state, during and just after reset.
        #12;
        check_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset("post_reset");

        // Encoding table, back-to-back at one word per cycle.
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1,
                           vecs[i].rs2, vecs[i].imm, vecs[i].target);
            tick();
            check_flag  ($sformatf("vec%0d ir_valid", i), bus.ir_valid, 1'b1);
            check_output($sformatf("vec%0d ir", i),       bus.ir,       vecs[i].exp_word);
            check_output($sformatf("vec%0d ir_addr", i),  bus.ir_addr,  BASE + 32'(4 * i));
        end
        bus.in_valid = 1'b0;
        tick();
        check_flag  ("vec drain ir_valid", bus.ir_valid, 1'b0);
        check_output("vec drain ir_addr",  bus.ir_addr,  BASE + 32'd24);

        // Fill to DEPTH with the consumer stalled, one extra push refused.
        do_flush(32'h300);
        bus.ir_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            check_flag($sformatf("fill%0d in_ready", k), bus.in_ready, k < DEPTH);
            if (k < DEPTH)
                fw[k] = ref_word(2'd1, 6'd1, 5'(k), 5'd0, 5'd0, 16'(k * 3 + 1), 26'd0);
            apply_stimulus(1'b1, 2'd1, 6'd1, 5'(k), 5'd0, 5'd0, 16'(k * 3 + 1), 26'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check_flag("full in_ready", bus.in_ready, 1'b0);
        bus.ir_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check_flag  ($sformatf("drain%0d ir_valid", k), bus.ir_valid, 1'b1);
            check_output($sformatf("drain%0d ir", k),       bus.ir,       fw[k]);
            check_output($sformatf("drain%0d ir_addr", k),  bus.ir_addr,  32'h300 + 32'(4 * k));
            tick();
        end
        check_flag  ("drain end ir_valid", bus.ir_valid, 1'b0);
        check_output("drain end ir_addr",  bus.ir_addr,  32'h310);

        // R word followed by HALT; input stays closed until flush.
        do_flush(32'h200);
        bus.ir_ready = 1'b0;
        apply_stimulus(1'b1, 2'd0, 6'h01, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0);
        tick();
        check_flag("pre_halt halted", bus.halted, 1'b0);
        apply_stimulus(1'b1, 2'd2, 6'h3F, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        bus.in_valid = 1'b0;
        check_flag  ("halt halted",   bus.halted,   1'b1);
        check_flag  ("halt in_ready", bus.in_ready, 1'b0);
        check_output("halt ir0",      bus.ir,       32'h0464_2800);
        bus.ir_ready = 1'b1;
        tick();
        check_output("halt ir1",      bus.ir,       32'hFC00_0000);
        check_output("halt ir1 addr", bus.ir_addr,  32'h204);
        tick();
        check_flag("halt empty ir_valid", bus.ir_valid, 1'b0);
        check_flag("halt hold halted",    bus.halted,   1'b1);
        apply_stimulus(1'b1, 2'd1, 6'd9, 5'd1, 5'd1, 5'd1, 16'd1, 26'd0);
        tick();
        bus.in_valid = 1'b0;
        check_flag("halt refuse ir_valid", bus.ir_valid, 1'b0);
        check_flag("halt refuse in_ready", bus.in_ready, 1'b0);
        do_flush(32'h500);
        check_flag  ("unhalt halted",   bus.halted,   1'b0);
        check_flag  ("unhalt in_ready", bus.in_ready, 1'b1);
        check_output("unhalt ir_addr",  bus.ir_addr,  32'h500);

        // Flush wins over a simultaneous push and pop.
        bus.ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 2'd2, 6'd4, 5'd0, 5'd0, 5'd0, 16'd0, 26'(k));
            tick();
        end
        apply_stimulus(1'b1, 2'd2, 6'd6, 5'd0, 5'd0, 5'd0, 16'd0, 26'h77);
        bus.ir_ready   = 1'b1;
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h100;
        tick();
        bus.flush    = 1'b0;
        bus.ir_ready = 1'b0;
        check_flag  ("flush ir_valid", bus.ir_valid, 1'b0);
        check_output("flush ir_addr",  bus.ir_addr,  32'h100);
        check_flag  ("flush in_ready", bus.in_ready, 1'b1);
        apply_stimulus(1'b1, 2'd2, 6'd7, 5'd0, 5'd0, 5'd0, 16'd0, 26'h55);
        tick();
        bus.in_valid = 1'b0;
        check_flag  ("post_flush ir_valid", bus.ir_valid, 1'b1);
        check_output("post_flush ir",       bus.ir,       32'h1C00_0055);
        check_output("post_flush ir_addr",  bus.ir_addr,  32'h100);

        // Address wrap at the top of the 32-bit space.
        do_flush(32'hFFFF_FFFC);
        apply_stimulus(1'b1, 2'd1, 6'd3, 5'd1, 5'd2, 5'd0, 16'h1234, 26'd0);
        tick();
        bus.in_valid = 1'b0;
        check_output("wrap pre ir_addr", bus.ir_addr, 32'hFFFF_FFFC);
        bus.ir_ready = 1'b1;
        tick();
        check_output("wrap ir_addr",  bus.ir_addr,  32'h0);
        check_flag  ("wrap ir_valid", bus.ir_valid, 1'b0);

        // Reserved format.
        bus.ir_ready = 1'b0;
        apply_stimulus(1'b1, 2'd3, 6'd5, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h123);
        tick();
        bus.in_valid = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
        check_flag("rsv ir_valid", bus.ir_valid, 1'b0);
        check_flag("rsv err",      bus.err,      1'b1);
        tick();
        check_flag("rsv err held", bus.err,      1'b1);
`else
        check_flag  ("rsv ir_valid", bus.ir_valid, 1'b1);
        check_output("rsv ir",       bus.ir,       32'h1400_0123);
        check_flag  ("rsv err",      bus.err,      1'b0);
`endif

        // Randomized run against the queue model.
        do_flush(32'h4000);
        mq.delete();
        m_addr = 32'h4000;
        m_halt = 1'b0;
        m_err  = CHECK_EN;
        for (int c = 0; c < 400; c++) begin
            logic        v, rdy_in, fl, m_rdy;
            logic [1:0]  fmt;
            logic [5:0]  op;
            logic [4:0]  rd, rs1, rs2;
            logic [15:0] imm;
            logic [25:0] tgt;
            logic [31:0] fa;

            check_flag("rnd ir_valid", bus.ir_valid, mq.size() > 0);
            if (mq.size() > 0)
                check_output("rnd ir", bus.ir, mq[0]);
            check_output("rnd ir_addr",  bus.ir_addr,  m_addr);
            check_flag  ("rnd in_ready", bus.in_ready, (mq.size() < DEPTH) && !m_halt);
            check_flag  ("rnd halted",   bus.halted,   m_halt);
            check_flag  ("rnd err",      bus.err,      m_err);

            v      = 1'($urandom_range(0, 1));
            fmt    = 2'($urandom_range(0, 3));
            op     = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
            rd     = 5'($urandom);
            rs1    = 5'($urandom);
            rs2    = 5'($urandom);
            imm    = 16'($urandom);
            tgt    = 26'($urandom);
            rdy_in = ($urandom_range(0, 3) != 0);
            fl     = ($urandom_range(0, 15) == 0);
            fa     = $urandom() & 32'hFFFF_FFFC;

            apply_stimulus(v, fmt, op, rd, rs1, rs2, imm, tgt);
            bus.ir_ready   = rdy_in;
            bus.flush      = fl;
            bus.flush_addr = fa;

            if (fl) begin
                mq.delete();
                m_addr = fa;
                m_halt = 1'b0;
            end else begin
                m_rdy = (mq.size() < DEPTH) && !m_halt;
                if ((mq.size() > 0) && rdy_in) begin
                    void'(mq.pop_front());
                    m_addr = m_addr + 32'd4;
                end
                if (v && m_rdy) begin
                    if ((fmt == 2'd3) && CHECK_EN) begin
                        m_err = 1'b1;
                    end else begin
                        mq.push_back(ref_word(fmt, op, rd, rs1, rs2, imm, tgt));
                        if (op == 6'h3F)
                            m_halt = 1'b1;
                    end
                end
            end
            tick();
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        // Asynchronous reset in the middle of a queued, halted stream.
        do_flush(32'h700);
        bus.ir_ready = 1'b0;
        apply_stimulus(1'b1, 2'd1, 6'd2, 5'd1, 5'd1, 5'd0, 16'd5, 26'd0);
        tick();
        apply_stimulus(1'b1, 2'd2, 6'h3F, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick();
        bus.in_valid = 1'b0;
        check_flag("pre_rst halted",   bus.halted,   1'b1);
        check_flag("pre_rst ir_valid", bus.ir_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_reset("after_mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
